// File: rtl/if_prefetch_unit.sv
// Instruction-fetch front end: issues sequential fetches under a credit limit, buffers
// returned words with their PCs in a small FIFO, and flushes on branch/jump redirects.
module if_prefetch_unit #(
    parameter int unsigned     XLEN   = 32,
    parameter int unsigned     DEPTH  = 4,
    parameter logic [XLEN-1:0] RST_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_resp_valid_i,
    input  logic [XLEN-1:0] imem_resp_data_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [XLEN-1:0] inst_data_o,
    output logic [XLEN-1:0] inst_pc_o
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam logic [CntW:0] DepthW = DEPTH[CntW:0];

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [CntW-1:0] count_q, count_d;
    logic [CntW-1:0] inflight_q, inflight_d;
    logic [CntW-1:0] drop_q, drop_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [XLEN-1:0] fifo_data_q [DEPTH];
    logic [XLEN-1:0] fifo_pc_q   [DEPTH];

    logic [CntW:0]   credit_used;
    logic            req_valid;
    logic            req_fire;
    logic            inst_valid;
    logic            pop;
    logic            push;
    logic [XLEN-1:0] redirect_base;

    // Buffered plus outstanding never exceeds DEPTH, so a response always has a free slot.
    assign credit_used   = {1'b0, count_q} + {1'b0, inflight_q};
    assign req_valid     = !rst_i && !redirect_valid_i && (credit_used < DepthW);
    assign req_fire      = req_valid && imem_req_ready_i;
    assign inst_valid    = (count_q != '0);
    assign pop           = inst_valid && inst_ready_i;
    assign push          = imem_resp_valid_i && (drop_q == '0) && !redirect_valid_i;
    assign redirect_base = {redirect_pc_i[XLEN-1:2], 2'b00};

    assign imem_req_valid_o = req_valid;
    assign imem_req_addr_o  = fetch_pc_q;
    assign inst_valid_o     = inst_valid;
    assign inst_data_o      = inst_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign inst_pc_o        = inst_valid ? fifo_pc_q[rd_ptr_q] : '0;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        count_d    = count_q;
        drop_d     = drop_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        inflight_d = inflight_q + CntW'(req_fire) - CntW'(imem_resp_valid_i);

        if (redirect_valid_i) begin
            // Everything still outstanding after this cycle belongs to the old stream.
            fetch_pc_d = redirect_base;
            resp_pc_d  = redirect_base;
            count_d    = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            drop_d     = inflight_d;
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + XLEN'(4);
            end
            if (imem_resp_valid_i && (drop_q != '0)) begin
                drop_d = drop_q - CntW'(1);
            end
            if (push) begin
                resp_pc_d = resp_pc_q + XLEN'(4);
                wr_ptr_d  = wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PtrW'(1);
            end
            count_d = count_q + CntW'(push) - CntW'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc_q <= RST_PC;
            resp_pc_q  <= RST_PC;
            count_q    <= '0;
            inflight_q <= '0;
            drop_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the output mux hides entries whenever count is zero.
    always_ff @(posedge clk_i) begin
        if (push && !rst_i) begin
            fifo_data_q[wr_ptr_q] <= imem_resp_data_i;
            fifo_pc_q[wr_ptr_q]   <= resp_pc_q;
        end
    end

endmodule
